// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - four-wire defuse game FSM with countdown and cut detection
module bomb_controller #(
   parameter int unsigned START_COUNT = 30,
   parameter logic [7:0]  CODE        = 8'b11_00_10_01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       tick,
   input  logic [3:0] wire_in,
   input  logic       repeat_rst,
   output logic       armed,
   output logic       success,
   output logic       fail,
   output logic [5:0] countdown,
   output logic [2:0] stage
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_DEFUSED,
      S_EXPLODED
   } state_t;

   state_t     state_q;
   logic [3:0] sync1_q, sync2_q, prev_q;
   logic       armed_q, success_q, fail_q;
   logic [5:0] countdown_q;
   logic [2:0] stage_q;

   logic [3:0] cut_mask;
   logic [2:0] cut_cnt;
   logic [1:0] cut_idx;
   logic [1:0] code_sel;

   // Wire synchronizer plus previous-value register; reset to "all intact"
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
         prev_q  <= 4'b1111;
      end else begin
         sync1_q <= wire_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Cut events: synchronized 1->0 transitions; decode count, index and expected wire
   always_comb begin
      cut_mask = prev_q & ~sync2_q;
      cut_cnt  = 3'($countones(cut_mask));
      cut_idx  = 2'd0;
      case (cut_mask)
         4'b0010: cut_idx = 2'd1;
         4'b0100: cut_idx = 2'd2;
         4'b1000: cut_idx = 2'd3;
         default: cut_idx = 2'd0;
      endcase
      code_sel = CODE[1:0];
      case (stage_q[1:0])
         2'd1:    code_sel = CODE[3:2];
         2'd2:    code_sel = CODE[5:4];
         2'd3:    code_sel = CODE[7:6];
         default: code_sel = CODE[1:0];
      endcase
   end

   // Game FSM with registered status outputs, countdown and stage counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         success_q   <= 1'b0;
         fail_q      <= 1'b0;
         countdown_q <= 6'd0;
         stage_q     <= 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (sync2_q == 4'b1111)) begin
                  state_q     <= S_ARMED;
                  armed_q     <= 1'b1;
                  countdown_q <= 6'(START_COUNT);
                  stage_q     <= 3'd0;
               end
            end
            S_ARMED: begin
               if ((cut_cnt >= 3'd2) || ((cut_cnt == 3'd1) && (cut_idx != code_sel))) begin
                  state_q <= S_EXPLODED;
                  armed_q <= 1'b0;
                  fail_q  <= 1'b1;
               end else if ((cut_cnt == 3'd1) && (stage_q == 3'd3)) begin
                  // Winning cut beats a coincident terminal tick; countdown freezes
                  state_q   <= S_DEFUSED;
                  armed_q   <= 1'b0;
                  success_q <= 1'b1;
                  stage_q   <= 3'd4;
               end else begin
                  if (cut_cnt == 3'd1) begin
                     stage_q <= stage_q + 3'd1;
                  end
                  if (tick) begin
                     if (countdown_q == 6'd1) begin
                        countdown_q <= 6'd0;
                        state_q     <= S_EXPLODED;
                        armed_q     <= 1'b0;
                        fail_q      <= 1'b1;
                     end else if (countdown_q != 6'd0) begin
                        countdown_q <= countdown_q - 6'd1;
                     end
                  end
               end
            end
            S_DEFUSED, S_EXPLODED: begin
               if (repeat_rst) begin
                  state_q     <= S_IDLE;
                  success_q   <= 1'b0;
                  fail_q      <= 1'b0;
                  countdown_q <= 6'd0;
                  stage_q     <= 3'd0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               armed_q <= 1'b0;
            end
         endcase
      end
   end

   assign armed     = armed_q;
   assign success   = success_q;
   assign fail      = fail_q;
   assign countdown = countdown_q;
   assign stage     = stage_q;

endmodule
